// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with a blanking guard at each digit change and frame-synchronous mask loading.
// Optional blink support is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
   parameter int unsigned PRESCALE     = 100000,
   parameter int unsigned GUARD        = 1000,
   parameter int unsigned BLINK_FRAMES = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit_en,
   input  logic [3:0] blink_mask,
   input  logic       upd,
   output logic       upd_ack,
   output logic [1:0] sel,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [1:0]     sel_q;
   logic [3:0]     an_q;
   logic [3:0]     en_sh_q;
   logic           upd_ack_q;
   logic           frame_tick_q;

   logic           slot_end;
   logic           guard_end;
   logic           boundary;
   logic [3:0]     blink_off;
   logic [3:0]     lit_d;
   logic [3:0]     an_d;

   assign slot_end  = (cnt_q == CW'(PRESCALE - 1));
   assign guard_end = (cnt_q == CW'(GUARD - 1));
   assign boundary  = slot_end && (sel_q == 2'd3);

`ifdef SEG_SCAN_BLINK_EN
   localparam int unsigned FCW = $clog2(BLINK_FRAMES + 1);

   logic [3:0]     blink_sh_q;
   logic           phase_q;
   logic [FCW-1:0] frm_cnt_q;

   // Phase flips on the boundary edge itself, so the new frame already sees it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_sh_q <= 4'b0000;
         phase_q    <= 1'b0;
         frm_cnt_q  <= '0;
      end else if (boundary) begin
         if (upd) begin
            blink_sh_q <= blink_mask;
         end
         if (frm_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
            frm_cnt_q <= '0;
            phase_q   <= ~phase_q;
         end else begin
            frm_cnt_q <= frm_cnt_q + 1'b1;
         end
      end
   end

   assign blink_off = phase_q ? blink_sh_q : 4'b0000;
`else
   logic unused_blink;

   assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES == 0);
   assign blink_off    = 4'b0000;
`endif

   always_comb begin
      lit_d = en_sh_q & ~blink_off;
      an_d  = 4'b1111;
      if (lit_d[sel_q]) begin
         an_d[sel_q] = 1'b0;
      end
   end

   // An is only ever opened on the guard-end edge, never together with a sel change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         sel_q        <= 2'd0;
         an_q         <= 4'b1111;
         en_sh_q      <= 4'b1111;
         upd_ack_q    <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         upd_ack_q    <= boundary && upd;
         frame_tick_q <= boundary;
         if (boundary && upd) begin
            en_sh_q <= digit_en;
         end
         if (slot_end) begin
            cnt_q   <= '0;
            sel_q   <= sel_q + 2'd1;
            state_q <= ST_BLANK;
            an_q    <= 4'b1111;
         end else begin
            cnt_q <= cnt_q + 1'b1;
            if ((state_q == ST_BLANK) && guard_end) begin
               state_q <= ST_DRIVE;
               an_q    <= an_d;
            end
         end
      end
   end

   assign sel        = sel_q;
   assign an         = an_q;
   assign upd_ack    = upd_ack_q;
   assign frame_tick = frame_tick_q;

endmodule
